// File: rtl/register_pipe.sv
// register_pipe
//   Parametrised multi-stage retiming register. Each of DEPTH stages holds
//   WIDTH bits of data and a valid tag. The pipeline advances one stage on
//   every clock where CE=1. FLUSH drops every valid tag, and a synchronous
//   active-low reset clears the whole pipe. COUNT reports how many stages
//   currently hold valid tags. Every output is driven directly from a flop.
//
// Parameters
//   WIDTH        data width in bits (>=1)
//   DEPTH        number of stages, which is also the latency in enabled cycles (>=1)
//   RESET_VALUE  data value loaded into every stage on reset
//   GATE_INVALID 1: when I_VALID=0, stage 0 loads RESET_VALUE instead of I
//
// Ports
//   CLK      in   rising-edge clock
//   RESETN   in   synchronous reset, active low (highest priority)
//   CE       in   clock enable; 1 = advance pipeline one stage
//   FLUSH    in   clear all valid tags; no shift takes place that cycle
//   I        in   [WIDTH]  input data
//   I_VALID  in   input valid tag
//   O        out  [WIDTH]  data of the last stage
//   O_VALID  out  valid tag of the last stage
//   COUNT    out  [$clog2(DEPTH+1)]  number of valid stages
module register_pipe #(
   parameter int unsigned      WIDTH        = 2,
   parameter int unsigned      DEPTH        = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
   parameter bit               GATE_INVALID = 1'b0
) (
   input  logic                         CLK,
   input  logic                         RESETN,
   input  logic                         CE,
   input  logic                         FLUSH,
   input  logic [WIDTH-1:0]             I,
   input  logic                         I_VALID,
   output logic [WIDTH-1:0]             O,
   output logic                         O_VALID,
   output logic [$clog2(DEPTH+1)-1:0]   COUNT
);

   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] d_q [DEPTH];
   logic [WIDTH-1:0] d_d [DEPTH];
   logic [DEPTH-1:0] v_q, v_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   always_comb begin
      d_d   = d_q;
      v_d   = v_q;
      cnt_d = cnt_q;
      if (FLUSH) begin
         // Data is left in place; only the tags are cleared.
         v_d   = '0;
         cnt_d = '0;
      end else if (CE) begin
         d_d[0] = (GATE_INVALID && !I_VALID) ? RESET_VALUE : I;
         v_d[0] = I_VALID;
         for (int unsigned k = 1; k < DEPTH; k++) begin
            d_d[k] = d_q[k-1];
            v_d[k] = v_q[k-1];
         end
         // A word can enter and another leave on the same edge: net change 0.
         cnt_d = cnt_q + CW'(I_VALID) - CW'(v_q[DEPTH-1]);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            d_q[k] <= RESET_VALUE;
         end
         v_q   <= '0;
         cnt_q <= '0;
      end else begin
         d_q   <= d_d;
         v_q   <= v_d;
         cnt_q <= cnt_d;
      end
   end

   assign O       = d_q[DEPTH-1];
   assign O_VALID = v_q[DEPTH-1];
   assign COUNT   = cnt_q;

endmodule

// File: tb/tb_register_pipe.sv
// Testbench for register_pipe.
//   u_dut0: WIDTH=2, DEPTH=4, RESET_VALUE=0, GATE_INVALID=0.
//     Valid words are pushed into an expected-data queue when they are driven;
//     a monitor pops that queue whenever a new valid word reaches the output.
//     Occupancy is modelled as a window holding the valid tags of the last
//     DEPTH enabled inputs.
//   u_dut1: WIDTH=2, DEPTH=1, RESET_VALUE=1, GATE_INVALID=1, directed sequence.
module tb_register_pipe;

   localparam int unsigned D0 = 4;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn = 1'b1, ce = 1'b0, fl = 1'b0, iv = 1'b0;
   logic [1:0] din = '0;
   logic [1:0] o0;
   logic       ov0;
   logic [2:0] cnt0;

   logic       rstn1 = 1'b1, ce1 = 1'b0, fl1 = 1'b0, iv1 = 1'b0;
   logic [1:0] din1 = '0;
   logic [1:0] o1;
   logic       ov1;
   logic [0:0] cnt1;

   register_pipe #(.WIDTH(2), .DEPTH(D0), .RESET_VALUE(2'd0), .GATE_INVALID(1'b0)) u_dut0 (
      .CLK(clk), .RESETN(rstn), .CE(ce), .FLUSH(fl), .I(din), .I_VALID(iv),
      .O(o0), .O_VALID(ov0), .COUNT(cnt0)
   );

   register_pipe #(.WIDTH(2), .DEPTH(1), .RESET_VALUE(2'd1), .GATE_INVALID(1'b1)) u_dut1 (
      .CLK(clk), .RESETN(rstn1), .CE(ce1), .FLUSH(fl1), .I(din1), .I_VALID(iv1),
      .O(o1), .O_VALID(ov1), .COUNT(cnt1)
   );

   int checks = 0;
   int errors = 0;

   logic [1:0] exp_q [$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus; record what the output must eventually show.
   task automatic drive(input bit r, input bit f, input bit c, input bit v, input logic [1:0] d);
      @(negedge clk);
      rstn = r; fl = f; ce = c; iv = v; din = d;
      if (!r || f) exp_q.delete();
      else if (c && v) exp_q.push_back(d);
   endtask

   // Monitor for u_dut0.
   bit         armed = 1'b0;
   bit         wq [$];
   logic [1:0] o_prev, exp_d;
   bit         s_r, s_f, s_c, s_v;

   always @(posedge clk) begin
      s_r = rstn; s_f = fl; s_c = ce; s_v = iv; o_prev = o0;
      #1;
      if (!s_r) begin
         armed = 1'b1;
         wq.delete();
         for (int k = 0; k < D0; k++) wq.push_back(1'b0);
         chk("reset_O", int'(o0), 0);
      end else if (armed) begin
         if (s_f) begin
            for (int k = 0; k < D0; k++) wq[k] = 1'b0;
            chk("flush_O_hold", int'(o0), int'(o_prev));
         end else if (s_c) begin
            wq.push_front(s_v);
            void'(wq.pop_back());
            if (wq[D0-1]) begin
               if (exp_q.size() == 0) begin
                  chk("scoreboard_underflow", 1, 0);
               end else begin
                  exp_d = exp_q.pop_front();
                  chk("data_O", int'(o0), int'(exp_d));
               end
            end
         end else begin
            chk("stall_O_hold", int'(o0), int'(o_prev));
         end
      end
      if (armed) begin
         int sum;
         sum = 0;
         foreach (wq[k]) sum += int'(wq[k]);
         chk("O_VALID", int'(ov0), int'(wq[D0-1]));
         chk("COUNT", int'(cnt0), sum);
      end
   end

   task automatic step1(input bit r, input bit f, input bit c, input bit v, input logic [1:0] d,
                        input int eo, input int ev, input int ec);
      @(negedge clk);
      rstn1 = r; fl1 = f; ce1 = c; iv1 = v; din1 = d;
      @(posedge clk);
      #1;
      chk("d1_O", int'(o1), eo);
      chk("d1_O_VALID", int'(ov1), ev);
      chk("d1_COUNT", int'(cnt1), ec);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      // T1: reset wins over CE and valid input
      drive(0, 0, 1, 1, 2'd3);
      // T2: latency, fill to 4
      drive(1, 0, 1, 1, 2'd1);
      drive(1, 0, 1, 1, 2'd2);
      drive(1, 0, 1, 1, 2'd3);
      drive(1, 0, 1, 1, 2'd0);
      for (int k = 0; k < 4; k++) drive(1, 0, 1, 0, 2'd0);
      // T3: stall two cycles after the second word
      drive(1, 0, 1, 1, 2'd1);
      drive(1, 0, 1, 1, 2'd2);
      drive(1, 0, 0, 0, 2'd0);
      drive(1, 0, 0, 1, 2'd3);
      drive(1, 0, 1, 1, 2'd3);
      drive(1, 0, 1, 1, 2'd0);
      // T4: pipe full, then flush with CE=1 and a valid input
      drive(1, 0, 1, 1, 2'd2);
      drive(1, 0, 1, 1, 2'd1);
      drive(1, 1, 1, 1, 2'd3);
      drive(1, 0, 0, 0, 2'd0);
      // T5: alternating bubbles
      for (int k = 0; k < 10; k++) drive(1, 0, 1, (k % 2) == 0, 2'(k));
      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         bit r, f, c, v;
         r = ($urandom_range(0, 99) >= 2);
         f = ($urandom_range(0, 99) < 5);
         c = ($urandom_range(0, 99) < 75);
         v = ($urandom_range(0, 99) < 60);
         drive(r, f, c, v, 2'($urandom_range(0, 3)));
      end
      // Drain
      for (int k = 0; k <= D0; k++) drive(1, 0, 1, 0, 2'd0);
      drive(1, 0, 0, 0, 2'd0);
      @(posedge clk);
      #2;
      chk("scoreboard_leftover", exp_q.size(), 0);

      // T6: DEPTH=1, GATE_INVALID=1, RESET_VALUE=1
      step1(0, 0, 1, 1, 2'd3, 1, 0, 0);
      step1(1, 0, 1, 1, 2'd2, 2, 1, 1);
      step1(0, 0, 1, 1, 2'd2, 1, 0, 0);
      step1(1, 0, 1, 0, 2'd3, 1, 0, 0);
      step1(1, 0, 1, 1, 2'd3, 3, 1, 1);
      step1(1, 0, 1, 1, 2'd0, 0, 1, 1);
      step1(1, 1, 1, 1, 2'd2, 0, 0, 0);
      step1(1, 0, 0, 1, 2'd2, 0, 0, 0);
      step1(1, 0, 1, 0, 2'd2, 1, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
